// File: rtl/simon_ctrl_if.sv
// rtl/simon_ctrl_if.sv - host/datapath control bundle for the Simon 64/128 sequencer
interface simon_ctrl_if #(
  parameter int ROUNDS = 44
);
  localparam int RIDX_W = $clog2(ROUNDS);

  logic [1:0]        data_rdy;
  logic              debug_port;
  logic              pt_shift_en;
  logic              key_shift_en;
  logic              round_en;
  logic [RIDX_W-1:0] round_idx;
  logic              out_shift_en;
  logic              out_sel;
  logic              valid;
  logic              busy;
  logic              err;

  modport master (
    output data_rdy, debug_port,
    input  pt_shift_en, key_shift_en, round_en, round_idx,
    input  out_shift_en, out_sel, valid, busy, err
  );

  modport slave (
    input  data_rdy, debug_port,
    output pt_shift_en, key_shift_en, round_en, round_idx,
    output out_shift_en, out_sel, valid, busy, err
  );
endinterface

// File: rtl/simon_ctrl.sv
// rtl/simon_ctrl.sv - load counting, round scheduling and serial output sequencing for Simon 64/128
module simon_ctrl #(
  parameter int BLOCK_W = 64,
  parameter int KEY_W   = 128,
  parameter int ROUNDS  = 44
) (
  input  logic         clk,
  input  logic         reset,
  simon_ctrl_if.slave  bus
);
  localparam int RIDX_W  = $clog2(ROUNDS);
  localparam int PT_CW   = $clog2(BLOCK_W + 1);
  localparam int KEY_CW  = $clog2(KEY_W + 1);
  localparam int OUT_MAX = (KEY_W > BLOCK_W) ? KEY_W : BLOCK_W;
  localparam int OUT_CW  = $clog2(OUT_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENCRYPT = 2'd1,
    S_OUTPUT  = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e            state_q,     state_d;
  logic [PT_CW-1:0]  pt_cnt_q,    pt_cnt_d;
  logic [KEY_CW-1:0] key_cnt_q,   key_cnt_d;
  logic              pt_ok_q,     pt_ok_d;
  logic              key_ok_q,    key_ok_d;
  logic [RIDX_W-1:0] round_idx_q, round_idx_d;
  logic [OUT_CW-1:0] out_cnt_q,   out_cnt_d;
  logic              out_sel_q,   out_sel_d;
  logic [1:0]        prev_cmd_q,  prev_cmd_d;

  logic              pt_shift_c, key_shift_c, round_c, out_shift_c, valid_c, err_c;
  logic [OUT_CW-1:0] out_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pt_cnt_q    <= '0;
      key_cnt_q   <= '0;
      pt_ok_q     <= 1'b0;
      key_ok_q    <= 1'b0;
      round_idx_q <= '0;
      out_cnt_q   <= '0;
      out_sel_q   <= 1'b0;
      prev_cmd_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      pt_cnt_q    <= pt_cnt_d;
      key_cnt_q   <= key_cnt_d;
      pt_ok_q     <= pt_ok_d;
      key_ok_q    <= key_ok_d;
      round_idx_q <= round_idx_d;
      out_cnt_q   <= out_cnt_d;
      out_sel_q   <= out_sel_d;
      prev_cmd_q  <= prev_cmd_d;
    end
  end

  assign out_last = out_sel_q ? OUT_CW'(KEY_W - 1) : OUT_CW'(BLOCK_W - 1);

  always_comb begin
    state_d     = state_q;
    pt_cnt_d    = pt_cnt_q;
    key_cnt_d   = key_cnt_q;
    pt_ok_d     = pt_ok_q;
    key_ok_d    = key_ok_q;
    round_idx_d = round_idx_q;
    out_cnt_d   = out_cnt_q;
    out_sel_d   = out_sel_q;
    prev_cmd_d  = bus.data_rdy;
    pt_shift_c  = 1'b0;
    key_shift_c = 1'b0;
    round_c     = 1'b0;
    out_shift_c = 1'b0;
    valid_c     = 1'b0;
    err_c       = 1'b0;

    case (state_q)
      S_IDLE: begin
        case (bus.data_rdy)
          2'd1: begin
            // Counting restarts on every new load run so a partial earlier run never counts.
            pt_shift_c = 1'b1;
            if (prev_cmd_q != 2'd1)
              pt_cnt_d = PT_CW'(1);
            else if (pt_cnt_q != PT_CW'(BLOCK_W))
              pt_cnt_d = pt_cnt_q + 1'b1;
            pt_ok_d = (pt_cnt_d == PT_CW'(BLOCK_W));
          end
          2'd2: begin
            key_shift_c = 1'b1;
            if (prev_cmd_q != 2'd2)
              key_cnt_d = KEY_CW'(1);
            else if (key_cnt_q != KEY_CW'(KEY_W))
              key_cnt_d = key_cnt_q + 1'b1;
            key_ok_d = (key_cnt_d == KEY_CW'(KEY_W));
          end
          2'd3: begin
            if (prev_cmd_q != 2'd3) begin
              if (pt_ok_q && key_ok_q) begin
                out_sel_d   = bus.debug_port;
                round_idx_d = '0;
                state_d     = S_ENCRYPT;
              end else begin
                err_c = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
      S_ENCRYPT: begin
        round_c = 1'b1;
        if (round_idx_q == RIDX_W'(ROUNDS - 1)) begin
          round_idx_d = '0;
          out_cnt_d   = '0;
          state_d     = S_OUTPUT;
        end else begin
          round_idx_d = round_idx_q + 1'b1;
        end
      end
      S_OUTPUT: begin
        valid_c     = 1'b1;
        out_shift_c = 1'b1;
        if (out_cnt_q == out_last) begin
          out_cnt_d = '0;
          state_d   = S_DONE;
        end else begin
          out_cnt_d = out_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        // The key register was consumed by the schedule, so both loads must be repeated.
        pt_cnt_d  = '0;
        key_cnt_d = '0;
        pt_ok_d   = 1'b0;
        key_ok_d  = 1'b0;
        if (bus.data_rdy != 2'd3)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.pt_shift_en  = pt_shift_c  & ~reset;
  assign bus.key_shift_en = key_shift_c & ~reset;
  assign bus.round_en     = round_c     & ~reset;
  assign bus.out_shift_en = out_shift_c & ~reset;
  assign bus.valid        = valid_c     & ~reset;
  assign bus.err          = err_c       & ~reset;
  assign bus.round_idx    = round_idx_q;
  assign bus.out_sel      = out_sel_q;
  assign bus.busy         = (state_q == S_ENCRYPT) || (state_q == S_OUTPUT);
endmodule

// File: tb/tb_simon_ctrl.sv
// tb/tb_simon_ctrl.sv - randomized schedule-model bench for simon_ctrl
module tb_simon_ctrl;
  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 128;
  localparam int ROUNDS  = 44;
  localparam int RIDX_W  = $clog2(ROUNDS);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  simon_ctrl_if #(.ROUNDS(ROUNDS)) bus ();

  simon_ctrl #(.BLOCK_W(BLOCK_W), .KEY_W(KEY_W), .ROUNDS(ROUNDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Schedule model: an accepted encrypt at cycle T fixes rounds on T+1..T+ROUNDS and output after.
  int m_prev, m_pt_run, m_key_run, m_start, m_end;
  bit m_pt_ok, m_key_ok, m_active, m_sel;

  int o_pt, o_key, o_round, o_valid, o_err, o_sel1, o_onehot_bad;
  int e_pt, e_key, e_round, e_valid, e_err;
  int d_timing, d_first;

  logic             s_pt, s_key, s_round, s_out, s_sel, s_valid, s_busy, s_err;
  logic [RIDX_W-1:0] s_idx;

  task automatic model_reset();
    m_prev = 0; m_pt_run = 0; m_key_run = 0; m_start = 0; m_end = 0;
    m_pt_ok = 0; m_key_ok = 0; m_active = 0; m_sel = 0;
  endtask

  task automatic clear_counts();
    o_pt = 0; o_key = 0; o_round = 0; o_valid = 0; o_err = 0; o_sel1 = 0; o_onehot_bad = 0;
    e_pt = 0; e_key = 0; e_round = 0; e_valid = 0; e_err = 0;
    d_timing = 0; d_first = -1;
  endtask

  task automatic tick(input logic [1:0] cmd, input logic dbg, input logic rst);
    bit x_pt, x_key, x_round, x_valid, x_err;
    int x_idx;
    @(negedge clk);
    bus.data_rdy = cmd;
    bus.debug_port = dbg;
    reset = rst;
    #1;
    s_pt = bus.pt_shift_en; s_key = bus.key_shift_en; s_round = bus.round_en;
    s_idx = bus.round_idx; s_out = bus.out_shift_en; s_sel = bus.out_sel;
    s_valid = bus.valid; s_busy = bus.busy; s_err = bus.err;
    if (rst) begin
      model_reset();
    end else begin
      x_pt = 0; x_key = 0; x_round = 0; x_valid = 0; x_err = 0; x_idx = 0;
      if (m_active) begin
        if (cyc <= m_start + ROUNDS) begin
          x_round = 1;
          x_idx = cyc - m_start - 1;
        end else if (cyc <= m_end) begin
          x_valid = 1;
        end else begin
          m_pt_run = 0; m_key_run = 0; m_pt_ok = 0; m_key_ok = 0;
          if (cmd != 2'd3) m_active = 0;
        end
      end else begin
        if (cmd == 2'd1) begin
          x_pt = 1;
          m_pt_run = (m_prev == 1) ? ((m_pt_run < BLOCK_W) ? m_pt_run + 1 : BLOCK_W) : 1;
          m_pt_ok = (m_pt_run == BLOCK_W);
        end else if (cmd == 2'd2) begin
          x_key = 1;
          m_key_run = (m_prev == 2) ? ((m_key_run < KEY_W) ? m_key_run + 1 : KEY_W) : 1;
          m_key_ok = (m_key_run == KEY_W);
        end else if (cmd == 2'd3 && m_prev != 3) begin
          if (m_pt_ok && m_key_ok) begin
            m_active = 1;
            m_start = cyc;
            m_sel = dbg;
            m_end = cyc + ROUNDS + (dbg ? KEY_W : BLOCK_W);
          end else begin
            x_err = 1;
          end
        end
      end
      m_prev = int'(cmd);

      e_pt += int'(x_pt); e_key += int'(x_key); e_round += int'(x_round);
      e_valid += int'(x_valid); e_err += int'(x_err);
      o_pt += int'(s_pt); o_key += int'(s_key); o_round += int'(s_round);
      o_valid += int'(s_valid); o_err += int'(s_err);
      if (s_valid === 1'b1 && s_sel === 1'b1) o_sel1++;
      if (int'(s_pt) + int'(s_key) + int'(s_round) + int'(s_out) > 1) o_onehot_bad++;
      if (s_pt !== x_pt || s_key !== x_key || s_round !== x_round || s_valid !== x_valid ||
          s_out !== x_valid || s_err !== x_err || s_busy !== (x_round | x_valid) ||
          s_idx !== RIDX_W'(x_idx) || (x_valid && s_sel !== m_sel)) begin
        if (d_first < 0) d_first = cyc;
        d_timing++;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic reset_dut();
    tick(2'd0, 1'b0, 1'b1);
    tick(2'd0, 1'b0, 1'b1);
    clear_counts();
  endtask

  task automatic run(input logic [1:0] cmd, input logic dbg, input int n);
    for (int i = 0; i < n; i++) tick(cmd, dbg, 1'b0);
  endtask

  task automatic test_reset();
    reset_dut();
    tick(2'd0, 1'b0, 1'b0);
    checks++;
    if ({s_pt, s_key, s_round, s_idx, s_out, s_sel, s_valid, s_busy, s_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {s_pt, s_key, s_round, s_idx, s_out, s_sel, s_valid, s_busy, s_err});
    end
    tick(2'd3, 1'b0, 1'b0);
    checks++;
    if (s_err !== 1'b1) begin errors++; $display("FAIL reset_err: got %b required 1", s_err); end
  endtask

  task automatic test_basic();
    reset_dut();
    run(2'd1, 1'b0, BLOCK_W);
    run(2'd2, 1'b0, KEY_W);
    run(2'd3, 1'b0, 1);
    run(2'd0, 1'b0, 120);
    checks++; if (o_pt !== BLOCK_W) begin errors++; $display("FAIL basic_pt: got %0d required %0d", o_pt, BLOCK_W); end
    checks++; if (o_key !== KEY_W) begin errors++; $display("FAIL basic_key: got %0d required %0d", o_key, KEY_W); end
    checks++; if (o_round !== ROUNDS) begin errors++; $display("FAIL basic_rounds: got %0d required %0d", o_round, ROUNDS); end
    checks++; if (o_valid !== BLOCK_W) begin errors++; $display("FAIL basic_valid: got %0d required %0d", o_valid, BLOCK_W); end
    checks++; if (o_err !== 0) begin errors++; $display("FAIL basic_err: got %0d required 0", o_err); end
    checks++; if (d_timing !== 0) begin errors++; $display("FAIL basic_timing: got %0d bad cycles (first %0d) required 0", d_timing, d_first); end
  endtask

  task automatic test_short_load();
    reset_dut();
    run(2'd1, 1'b0, BLOCK_W - 1);
    run(2'd2, 1'b0, KEY_W);
    run(2'd3, 1'b0, 3);
    run(2'd0, 1'b0, 5);
    checks++; if (o_err !== 1) begin errors++; $display("FAIL short_err: got %0d required 1", o_err); end
    checks++; if (o_round !== 0) begin errors++; $display("FAIL short_rounds: got %0d required 0", o_round); end
    checks++; if (d_timing !== 0) begin errors++; $display("FAIL short_timing: got %0d bad cycles required 0", d_timing); end
  endtask

  task automatic test_key_mode();
    reset_dut();
    run(2'd1, 1'b0, BLOCK_W);
    run(2'd2, 1'b0, KEY_W);
    clear_counts();
    run(2'd3, 1'b1, 1);
    run(2'd0, 1'b1, 20);
    for (int i = 0; i < 100; i++) tick(2'($urandom_range(0, 3)), 1'b0, 1'b0);
    run(2'd0, 1'b0, 80);
    checks++; if (o_valid !== KEY_W) begin errors++; $display("FAIL key_valid: got %0d required %0d", o_valid, KEY_W); end
    checks++; if (o_sel1 !== KEY_W) begin errors++; $display("FAIL key_outsel: got %0d required %0d", o_sel1, KEY_W); end
    checks++; if (o_pt + o_key + o_err !== 0) begin errors++; $display("FAIL key_ignored_cmds: got %0d required 0", o_pt + o_key + o_err); end
    checks++; if (d_timing !== 0) begin errors++; $display("FAIL key_timing: got %0d bad cycles (first %0d) required 0", d_timing, d_first); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    run(2'd1, 1'b0, BLOCK_W);
    run(2'd2, 1'b0, KEY_W);
    run(2'd3, 1'b0, 1);
    run(2'd0, 1'b0, 20);
    tick(2'd0, 1'b0, 1'b1);
    checks++; if (s_idx !== RIDX_W'(20)) begin errors++; $display("FAIL mid_ridx: got %0d required 20", s_idx); end
    tick(2'd0, 1'b0, 1'b0);
    checks++;
    if ({s_pt, s_key, s_round, s_idx, s_out, s_sel, s_valid, s_busy, s_err} !== '0) begin
      errors++;
      $display("FAIL mid_outputs: got %b required all zero",
               {s_pt, s_key, s_round, s_idx, s_out, s_sel, s_valid, s_busy, s_err});
    end
    tick(2'd3, 1'b0, 1'b0);
    checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL mid_err: got %b required 1", s_err); end
    tick(2'd0, 1'b0, 1'b0);
    checks++; if (s_round !== 1'b0) begin errors++; $display("FAIL mid_no_round: got %b required 0", s_round); end
  endtask

  task automatic test_hold();
    reset_dut();
    run(2'd1, 1'b0, BLOCK_W);
    run(2'd2, 1'b0, KEY_W);
    run(2'd3, 1'b0, 250);
    run(2'd0, 1'b0, 2);
    run(2'd3, 1'b0, 3);
    run(2'd0, 1'b0, 3);
    checks++; if (o_round !== ROUNDS) begin errors++; $display("FAIL hold_rounds: got %0d required %0d", o_round, ROUNDS); end
    checks++; if (o_err !== 1) begin errors++; $display("FAIL hold_err: got %0d required 1", o_err); end
    checks++; if (d_timing !== 0) begin errors++; $display("FAIL hold_timing: got %0d bad cycles (first %0d) required 0", d_timing, d_first); end
  endtask

  task automatic test_overload_pause();
    reset_dut();
    run(2'd1, 1'b0, 70);
    run(2'd0, 1'b0, 5);
    run(2'd2, 1'b0, KEY_W);
    run(2'd3, 1'b0, 1);
    run(2'd0, 1'b0, 115);
    checks++; if (o_pt !== 70) begin errors++; $display("FAIL over_pt: got %0d required 70", o_pt); end
    checks++; if (o_round !== ROUNDS) begin errors++; $display("FAIL over_rounds: got %0d required %0d", o_round, ROUNDS); end
    checks++; if (o_valid !== BLOCK_W) begin errors++; $display("FAIL over_valid: got %0d required %0d", o_valid, BLOCK_W); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      reset_dut();
      for (int seg = 0; seg < 12; seg++) begin
        logic [1:0] c;
        int n;
        c = 2'($urandom_range(0, 3));
        case (c)
          2'd1:    n = $urandom_range(55, 75);
          2'd2:    n = $urandom_range(118, 135);
          2'd3:    n = $urandom_range(1, 4);
          default: n = $urandom_range(1, 6);
        endcase
        run(c, 1'($urandom_range(0, 1)), n);
      end
      run(2'd0, 1'b0, 200);
      checks++; if (d_timing !== 0) begin errors++; $display("FAIL rand_timing it%0d: got %0d bad cycles (first %0d) required 0", it, d_timing, d_first); end
      checks++; if (o_round !== e_round) begin errors++; $display("FAIL rand_rounds it%0d: got %0d required %0d", it, o_round, e_round); end
      checks++; if (o_valid !== e_valid) begin errors++; $display("FAIL rand_valid it%0d: got %0d required %0d", it, o_valid, e_valid); end
      checks++; if (o_err !== e_err) begin errors++; $display("FAIL rand_err it%0d: got %0d required %0d", it, o_err, e_err); end
      checks++; if (o_pt + o_key !== e_pt + e_key) begin errors++; $display("FAIL rand_loads it%0d: got %0d required %0d", it, o_pt + o_key, e_pt + e_key); end
      checks++; if (o_onehot_bad !== 0) begin errors++; $display("FAIL rand_onehot it%0d: got %0d required 0", it, o_onehot_bad); end
    end
  endtask

  initial begin
    bus.data_rdy = 2'd0;
    bus.debug_port = 1'b0;
    model_reset();
    clear_counts();
    test_reset();
    test_basic();
    test_short_load();
    test_key_mode();
    test_reset_mid();
    test_hold();
    test_overload_pause();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/simon_ctrl.md
Name: simon_ctrl

Overview:
- Sequencing controller for the bit-serial Simon 64/128 datapath.
- Decodes the 2-bit host command and counts serial load bits for plaintext and key.
- Schedules the 44 encryption rounds, then streams the ciphertext or key out serially with a valid strobe.
- Holds no cipher data; it drives only enables and selects into the datapath registers.

Parameters:
- BLOCK_W, 64: plaintext/ciphertext bits shifted in and out.
- KEY_W, 128: key bits shifted in and out.
- ROUNDS, 44: encryption rounds per block. RIDX_W = $clog2(ROUNDS) is a derived localparam, 6 by default.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- data_rdy  in  2  command: 0 idle, 1 load plaintext, 2 load key, 3 encrypt.
- debug_port  in  1  0 = output ciphertext, 1 = output key; sampled at encrypt start.
- pt_shift_en  out  1  shift data_in into the block register this cycle.
- key_shift_en  out  1  shift data_in into the key register this cycle.
- round_en  out  1  datapath performs one round plus one key-schedule step.
- round_idx  out  RIDX_W  current round; selects the z-sequence bit.
- out_shift_en  out  1  shift the selected output register by one bit.
- out_sel  out  1  latched debug_port; datapath mux select for cipher_out.
- valid  out  1  serial output bit is valid this cycle.
- busy  out  1  high in ENCRYPT and OUTPUT.
- err  out  1  one-cycle pulse on a rejected encrypt command.

Behaviour:
- States: IDLE, ENCRYPT, OUTPUT, DONE. All state changes and outputs are synchronous to clk.
- Reset (any state, including mid-operation): state=IDLE, pt_cnt=0, key_cnt=0, pt_ok=0, key_ok=0, round_idx=0, out_cnt=0, out_sel=0, prev_cmd=0, all outputs 0.
- prev_cmd register holds data_rdy from the previous cycle.
- IDLE, data_rdy=1:
  - pt_shift_en=1 combinationally in the same cycle.
  - pt_cnt restarts at 1 when prev_cmd!=1; otherwise increments, saturating at BLOCK_W.
  - pt_ok=1 once pt_cnt reaches BLOCK_W. Extra bits keep shifting, so the last BLOCK_W bits win.
- IDLE, data_rdy=2: same rules using key_shift_en, key_cnt, key_ok and KEY_W.
- Re-entering a load command clears the matching ok flag until the count completes again.
- IDLE, data_rdy=3 with prev_cmd!=3 (edge):
  - If pt_ok and key_ok: latch out_sel=debug_port, set round_idx=0, go to ENCRYPT.
  - Otherwise: err=1 for that one cycle and stay in IDLE.
- Holding data_rdy=3 does not retrigger.
- ENCRYPT:
  - round_en=1 every cycle; round_idx steps 0..ROUNDS-1, one per cycle.
  - After the cycle with round_idx=ROUNDS-1, go to OUTPUT with out_cnt=0.
- OUTPUT:
  - valid=1 and out_shift_en=1 every cycle.
  - out_cnt counts to N-1, where N=BLOCK_W if out_sel=0, else KEY_W. Then go to DONE.
- DONE:
  - Clears pt_ok, key_ok, pt_cnt and key_cnt; the key register has been consumed by the schedule, so the host must reload both.
  - Stays in DONE while data_rdy=3. Returns to IDLE once data_rdy!=3.
- Timing, with the start edge sampled at cycle T:
  - round_en high T+1..T+44.
  - valid high T+45..T+108 (to T+172 in key mode).
  - busy is high exactly while round_en or valid is high.
- Commands during ENCRYPT, OUTPUT and DONE are ignored: no shift enables, no err, no abort.
- Shift enables are never asserted outside IDLE.
- Exactly one of pt_shift_en, key_shift_en, round_en, out_shift_en is high in any cycle, or none.

Test Plan:
- Load 64 plaintext bits (data_rdy=1), 128 key bits (data_rdy=2), then data_rdy=3 with debug_port=0 -> pt_shift_en high 64 cycles; key_shift_en high 128 cycles; round_en high 44 cycles with round_idx 0..43; valid high exactly 64 cycles. With the Simon64/128 datapath and key 1b1a1918_13121110_0b0a0908_03020100, pt 656b696c_20646e75 -> ct 44c8fc20_b9dfa07a.
- Encrypt edge after only 63 plaintext bits -> err=1 for one cycle, state stays IDLE, round_en stays 0.
- Same full run with debug_port=1 at start, toggled to 0 mid-run -> out_sel stays 1, valid high 128 cycles.
- Assert reset at round_idx=20 -> next cycle all outputs 0; a following encrypt edge gives err=1 because flags were cleared.
- Hold data_rdy=3 through completion, then 0, then 3 again without reloading -> one encryption only; the second edge gives err=1.
- Load 70 plaintext bits, pause 5 cycles at data_rdy=0, load key, encrypt -> pt_ok set; encryption runs normally.
